gpr_file_2r1w: RTL and testbench

Parametrised general-purpose register file with two synchronous read ports, one write port, write-first bypass, an optional hardwired zero register and a per-register busy scoreboard. It replaces the single-port 4×8 GPR in the CPU datapath. Decode reads both source operands in one cycle, and the scoreboard lets the pipeline detect operands whose producing instruction has not yet written back.

---
 rtl/gpr_file_2r1w.sv | 117 +++++++++++
 tb/tb_gpr_file_2r1w.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gpr_file_2r1w.sv
// gpr_file_2r1w
//   General-purpose register file: two registered read ports, one write
//   port, write-first bypass, optional hardwired zero register and a
//   per-register busy scoreboard for in-flight producers.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   read_enable_x/read_address_x capture port x (x = a, b) on this edge
//   read_data_x/read_busy_x      registered data / busy for port x
//   write_enable/write_address/write_data   write port
//   reserve_enable/reserve_address          mark a register busy
//   busy_mask                    current busy bit per register
module gpr_file_2r1w #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read_enable_a,
  input  logic [ADDR_WIDTH-1:0]     read_address_a,
  output logic [DATA_WIDTH-1:0]     read_data_a,
  output logic                      read_busy_a,
  input  logic                      read_enable_b,
  input  logic [ADDR_WIDTH-1:0]     read_address_b,
  output logic [DATA_WIDTH-1:0]     read_data_b,
  output logic                      read_busy_b,
  input  logic                      write_enable,
  input  logic [ADDR_WIDTH-1:0]     write_address,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      reserve_enable,
  input  logic [ADDR_WIDTH-1:0]     reserve_address,
  output logic [2**ADDR_WIDTH-1:0]  busy_mask
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  write_ok;
  logic                  reserve_ok;
  logic [DATA_WIDTH-1:0] read_value_a;
  logic [DATA_WIDTH-1:0] read_value_b;

  // Writes/reserves aimed at a hardwired zero register are dropped here so
  // that neither storage, scoreboard nor bypass ever sees them.
  always_comb begin
    write_ok   = write_enable;
    reserve_ok = reserve_enable;
    if (HAS_ZERO && (write_address == '0))
      write_ok = 1'b0;
    if (HAS_ZERO && (reserve_address == '0))
      reserve_ok = 1'b0;
  end

  // Clear then set: a same-edge reserve beats the retiring write.
  always_comb begin
    busy_next = busy;
    if (write_ok)
      busy_next[write_address] = 1'b0;
    if (reserve_ok)
      busy_next[reserve_address] = 1'b1;
  end

  always_comb begin
    read_value_a = regs[read_address_a];
    if (write_ok && (write_address == read_address_a))
      read_value_a = write_data;
    if (HAS_ZERO && (read_address_a == '0))
      read_value_a = '0;
  end

  always_comb begin
    read_value_b = regs[read_address_b];
    if (write_ok && (write_address == read_address_b))
      read_value_b = write_data;
    if (HAS_ZERO && (read_address_b == '0))
      read_value_b = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write_ok)
        regs[write_address] <= write_data;
      busy <= busy_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_a <= '0;
      read_busy_a <= 1'b0;
    end else if (read_enable_a) begin
      read_data_a <= read_value_a;
      read_busy_a <= busy_next[read_address_a];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_b <= '0;
      read_busy_b <= 1'b0;
    end else if (read_enable_b) begin
      read_data_b <= read_value_b;
      read_busy_b <= busy_next[read_address_b];
    end
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_gpr_file_2r1w.sv
module tb_gpr_file_2r1w;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Default configuration: 4 x 8, no zero register.
  logic       rea, reb, we, re;
  logic [1:0] raa, rab, wa, ra;
  logic [7:0] wd, rda, rdb;
  logic       rba, rbb;
  logic [3:0] bm;

  gpr_file_2r1w dut0 (
    .clock(clock), .reset(reset),
    .read_enable_a(rea), .read_address_a(raa), .read_data_a(rda), .read_busy_a(rba),
    .read_enable_b(reb), .read_address_b(rab), .read_data_b(rdb), .read_busy_b(rbb),
    .write_enable(we), .write_address(wa), .write_data(wd),
    .reserve_enable(re), .reserve_address(ra), .busy_mask(bm)
  );

  // Zero-register configuration: 8 x 16.
  logic        zrea, zreb, zwe, zre;
  logic [2:0]  zraa, zrab, zwa, zra;
  logic [15:0] zwd, zrda, zrdb;
  logic        zrba, zrbb;
  logic [7:0]  zbm;

  gpr_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset),
    .read_enable_a(zrea), .read_address_a(zraa), .read_data_a(zrda), .read_busy_a(zrba),
    .read_enable_b(zreb), .read_address_b(zrab), .read_data_b(zrdb), .read_busy_b(zrbb),
    .write_enable(zwe), .write_address(zwa), .write_data(zwd),
    .reserve_enable(zre), .reserve_address(zra), .busy_mask(zbm)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    rea = 0; reb = 0; we = 0; re = 0;
    raa = 0; rab = 0; wa = 0; ra = 0; wd = 0;
    zrea = 0; zreb = 0; zwe = 0; zre = 0;
    zraa = 0; zrab = 0; zwa = 0; zra = 0; zwd = 0;
  endtask

  // One active edge; outputs are stable 1 ns later, and inputs for the
  // next edge are driven from here.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    idle();
    // Enables held high through reset must have no effect.
    rea = 1; raa = 2'd0; we = 1; wa = 2'd0; wd = 8'hEE; re = 1; ra = 2'd1;
    @(posedge clock); @(posedge clock); #1;
    check("reset_rda", rda, 0);
    check("reset_bm", bm, 0);
    check("reset_zbm", zbm, 0);
    reset = 0;
    idle();

    // Reset between edges.
    we = 1; wa = 2'd2; wd = 8'hA5; tick();
    rea = 1; raa = 2'd2; re = 1; ra = 2'd1; tick();
    check("pre_reset_rda", rda, 8'hA5);
    check("pre_reset_bm", bm, 4'b0010);
    reset = 1; #1;
    check("async_rda", rda, 0);
    check("async_bm", bm, 0);
    reset = 0;
    rea = 1; raa = 2'd2; tick();
    check("post_reset_r2", rda, 0);

    // Fill and dual read.
    we = 1; wa = 0; wd = 8'h11; tick();
    we = 1; wa = 1; wd = 8'h22; tick();
    we = 1; wa = 2; wd = 8'h33; tick();
    we = 1; wa = 3; wd = 8'h44; tick();
    rea = 1; raa = 1; reb = 1; rab = 3; tick();
    check("dual_a_r1", rda, 8'h22);
    check("dual_b_r3", rdb, 8'h44);
    rea = 1; raa = 2; reb = 1; rab = 2; tick();
    check("same_a_r2", rda, 8'h33);
    check("same_b_r2", rdb, 8'h33);

    // Hold.
    rea = 1; raa = 1; tick();
    check("hold_first", rda, 8'h22);
    we = 1; wa = 1; wd = 8'h99; tick();
    check("hold_after_write", rda, 8'h22);
    tick();
    check("hold_idle", rda, 8'h22);
    rea = 1; raa = 1; tick();
    check("hold_reread", rda, 8'h99);

    // Bypass.
    we = 1; wa = 1; wd = 8'h5C; rea = 1; raa = 1; reb = 1; rab = 0; tick();
    check("bypass_a", rda, 8'h5C);
    check("bypass_b_r0", rdb, 8'h11);

    // Scoreboard.
    re = 1; ra = 3; rea = 1; raa = 3; reb = 1; rab = 1; tick();
    check("rsv_busy_a", rba, 1);
    check("rsv_data_a", rda, 8'h44);
    check("rsv_busy_b", rbb, 0);
    check("rsv_bm", bm, 4'b1000);
    we = 1; wa = 3; wd = 8'h77; rea = 1; raa = 3; tick();
    check("retire_bm", bm, 4'b0000);
    check("retire_busy_a", rba, 0);
    check("retire_data_a", rda, 8'h77);
    re = 1; ra = 2; we = 1; wa = 2; wd = 8'h66; rea = 1; raa = 2; tick();
    check("rsvwr_bm", bm, 4'b0100);
    check("rsvwr_busy_a", rba, 1);
    check("rsvwr_data_a", rda, 8'h66);

    // Zero register configuration.
    zwe = 1; zwa = 0; zwd = 16'hBEEF; tick();
    zre = 1; zra = 0; tick();
    zwe = 1; zwa = 7; zwd = 16'hFFFF; zre = 1; zra = 5; tick();
    check("zero_bm", zbm, 8'b0010_0000);
    zrea = 1; zraa = 0; zreb = 1; zrab = 7; tick();
    check("zero_r0_data", zrda, 0);
    check("zero_r0_busy", zrba, 0);
    check("zero_r7_data", zrdb, 16'hFFFF);
    // Same-edge write to r0 must not bypass.
    zwe = 1; zwa = 0; zwd = 16'h1234; zre = 1; zra = 0; zrea = 1; zraa = 0; tick();
    check("zero_nobypass", zrda, 0);
    check("zero_nobusy", zrba, 0);
    check("zero_bm0", zbm[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
